// File: rtl/router_pkt_tx.sv
// Packet source for the router 1x3 input port: buffers payload bytes in a FIFO and, on command,
// sends header, payload and parity bytes, stalling while the router reports busy.
module router_pkt_tx #(
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     pl_wr,
   input  logic [7:0]               pl_data,
   input  logic                     start,
   input  logic [1:0]               dest,
   input  logic [5:0]               len,
   input  logic                     inject_err,
   input  logic                     busy,
   output logic [7:0]               data_out,
   output logic                     pkt_valid,
   output logic [$clog2(DEPTH):0]   pl_count,
   output logic                     pl_full,
   output logic                     tx_active,
   output logic                     done,
   output logic                     cmd_err,
   output logic                     ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_GAP
   } state_t;

   state_t        r_state;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic [7:0]    r_data;
   logic          r_valid;
   logic [7:0]    r_acc;
   logic [5:0]    r_rem;
   logic          r_inj;
   logic [GW-1:0] r_gap;
   logic          r_done;
   logic          r_cmd_err;

   logic          w_full;
   logic          w_in_tx;
   logic          w_rd;
   logic          w_wr;
   logic          w_accept;
   logic [7:0]    w_rd_byte;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_in_tx   = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
   // A FIFO read happens exactly on payload transfer edges; it frees a slot for a same-edge write.
   assign w_rd      = w_in_tx && !busy && (r_rem != 6'd0);
   assign w_wr      = pl_wr && (!w_full || w_rd);
   assign w_accept  = start && (dest != 2'b11) && (len != 6'd0) && (CW'(len) <= r_count);
   assign w_rd_byte = r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= pl_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
         r_ovf   <= pl_wr && !w_wr;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_inj     <= 1'b0;
         r_gap     <= '0;
         r_done    <= 1'b0;
         r_cmd_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cmd_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_accept) begin
                     r_data  <= {len, dest};
                     r_valid <= 1'b1;
                     r_acc   <= {len, dest};
                     r_rem   <= len;
                     r_inj   <= inject_err;
                     r_state <= S_HEADER;
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end
            end
            S_HEADER, S_PAYLOAD: begin
               if (!busy) begin
                  if (r_rem != 6'd0) begin
                     r_data  <= w_rd_byte;
                     r_acc   <= r_acc ^ w_rd_byte;
                     r_rem   <= r_rem - 6'd1;
                     r_state <= S_PAYLOAD;
                  end else begin
                     r_data  <= r_acc ^ {7'b0, r_inj};
                     r_valid <= 1'b0;
                     r_state <= S_PARITY;
                  end
               end
            end
            S_PARITY: begin
               if (!busy) begin
                  r_data  <= '0;
                  r_done  <= 1'b1;
                  r_gap   <= '0;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap == GW'(GAP_CYCLES - 1)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out  = r_data;
   assign pkt_valid = r_valid;
   assign pl_count  = r_count;
   assign pl_full   = w_full;
   assign tx_active = (r_state != S_IDLE);
   assign done      = r_done;
   assign cmd_err   = r_cmd_err;
   assign ovf       = r_ovf;

endmodule
